// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div over a fixed
// busy window and commits the latched result when the countdown expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [2:0]  MDU_op,
    input  logic        md,
    input  logic        mt,
    input  logic        mf,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        busy,
    output logic        stall_md
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;

    state_t      state_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] res_hi_q, res_lo_q;
    logic        div0_q;
    logic [3:0]  cnt_q;
    logic        busy_q;

    logic [31:0] res_hi_d, res_lo_d;
    logic        div0_d;
    logic [3:0]  cnt_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, divu_b;

    // mf only selects the output through MDU_op; the flag itself carries no state
    logic unused_mf;
    assign unused_mf = mf;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide through magnitudes: 0x80000000 / -1 wraps back to 0x80000000
    assign a_mag  = A[31] ? (~A + 32'd1) : A;
    assign b_mag  = B[31] ? (~B + 32'd1) : B;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign divu_b = (B == 32'd0) ? 32'd1 : B;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;

    always_comb begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        div0_d   = 1'b0;
        cnt_d    = 4'(MULT_CYCLES);
        case (MDU_op)
            OP_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            OP_DIV: begin
                res_lo_d = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
                res_hi_d = A[31] ? (~r_mag + 32'd1) : r_mag;
                div0_d   = (B == 32'd0);
                cnt_d    = 4'(DIV_CYCLES);
            end
            default: begin
                res_lo_d = A / divu_b;
                res_hi_d = A % divu_b;
                div0_d   = (B == 32'd0);
                cnt_d    = 4'(DIV_CYCLES);
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            div0_q   <= 1'b0;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && md) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= cnt_d;
                        res_hi_q <= res_hi_d;
                        res_lo_q <= res_lo_d;
                        div0_q   <= div0_d;
                    end else if (en && mt) begin
                        if (MDU_op == OP_MTHI) hi_q <= A;
                        else if (MDU_op == OP_MTLO) lo_q <= A;
                    end
                end
                RUN: begin
                    // New md/mt commands are dropped here; only the countdown runs
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!div0_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign stall_md = busy_q | (en & md);
    assign out      = (MDU_op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the P6 pipeline, sitting in the E stage beside the ALU. It accepts the `MDU_op`/`md`/`mf`/`mt` controls that the stage controller produces from the decoded instruction, runs mult/multu/div/divu over a fixed multi-cycle latency, and owns the HI/LO registers. It exposes `busy` and `stall_md` so the hazard unit can hold any MDU-class instruction in D while an operation is in flight.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low: 0 clears all state immediately.
- `en`  in  1  E-stage instruction valid. 0 means bubble or flush, and all commands are ignored.
- `MDU_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- `md`  in  1  instruction is mult/multu/div/divu.
- `mt`  in  1  instruction is mthi/mtlo.
- `mf`  in  1  instruction is mfhi/mflo.
- `A`  in  32  forwarded rs value: multiplicand/dividend, or mt source.
- `B`  in  32  forwarded rt value: multiplier/divisor.
- `out`  out  32  HI when `MDU_op`=6, otherwise LO. Combinational from the HI/LO registers.
- `busy`  out  1  registered; high while an operation is counting.
- `stall_md`  out  1  `busy | (en & md)`. The hazard unit ORs this into the D-stage stall for md/mt/mf in D.

## Operation

Internal state:
- `HI`, `LO` (32 each).
- `res_hi`, `res_lo` (pending result).
- `cnt` (4 bits, enough for `DIV_CYCLES` ≤ 15).
- `busy`.

Two-state FSM:
- `IDLE`: `busy`=0.
- `RUN`: `busy`=1.

Transitions:
- `IDLE` → `RUN` on `en & md`.
  - Compute the result from `A`, `B` and latch it into `res_hi`/`res_lo`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
- `RUN`: `cnt` decrements each edge.
- On the edge where `cnt`=1: write `res_hi`/`res_lo` into `HI`/`LO`, clear `busy`, return to `IDLE`.

Arithmetic:
- mult: 64-bit signed product. HI = [63:32], LO = [31:0].
- multu: same split, unsigned.
- div (signed): LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient to LO, remainder to HI.
- Divisor `B`=0 (div or divu): operation still runs `DIV_CYCLES` busy cycles; HI and LO keep their prior values.

Move to/from HI/LO:
- mt in `IDLE` with `en`=1: op 4 writes HI ← `A` at the next edge; op 5 writes LO ← `A`.
- mf has no side effects; `out` selects HI or LO as above.

Ignored commands:
- `md` or `mt` arriving while `busy`=1 is ignored: no restart, no HI/LO write.
- The hazard unit must prevent this case. The bench checks the ignore behaviour anyway.
- Any command with `en`=0 is ignored.

Reset:
- Asserting `reset` (0) at any time, including mid-operation, aborts the operation.
- Clears HI=0, LO=0, `busy`=0, `cnt`=0, FSM=`IDLE`.

## Timing

- Reset values: `busy`=0, `stall_md`=0 with `en`=0, `out`=0.
- An md issued in E during cycle t:
  - `stall_md`=1 in cycle t (combinational).
  - `busy`=1 in cycles t+1 … t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO are updated at the edge ending cycle t+N.
  - `busy`=0 in cycle t+N+1, and `out` shows the new value in that cycle.
- Back-to-back md: a second md can be accepted at the earliest in cycle t+N+1.
- mt latency: one edge. An mf in the cycle after an mt reads the new value.
- mf during `busy`: `out` shows the stale HI/LO. Correctness relies on `stall_md`.
- Operand capture: `A`/`B` are sampled only on the start edge. Changes during `RUN` have no effect.

## Test plan

- Reset, then mult `A`=0xFFFFFFFD (-3), `B`=5: `busy` high for exactly 5 cycles. Then mfhi gives 0xFFFFFFFF and mflo gives 0xFFFFFFF1.
- multu 0xFFFFFFFF × 2: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. Then div -7/2 (0xFFFFFFF9, 2): 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi 0x12345678, mtlo 0x9ABCDEF0, then divu by 0: 10 busy cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- mult 6×7 started; in its 2nd busy cycle drive md=1 (divu 100/3) and mt=1 with `en`=1. Required: busy ends after 5 cycles total, HI=0, LO=42, and no later restart.
- div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Separately, md with `en`=0 leaves `busy`=0 and HI/LO unchanged.
- Start div 100/7, pull `reset` low in the 4th busy cycle (asynchronous, between edges): `busy` and HI/LO go to 0 immediately. After release, `busy` stays 0.
